// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB over one valid/ready
// memory port. Illegal instructions park the core in TRAP until reset.
module multi_cycle_core #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_PC   = 0,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  halt,
  output logic [7:0]            leds
);
  localparam int RIDX_W = $clog2(NUM_REGS);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0]           ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]           imm_q, imm_d, res_q, res_d;
  logic                  req_q, req_d;
  logic [7:0]            leds_q, leds_d;
  logic                  rf_we;
  logic [31:0]           regs_q [NUM_REGS];

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [RIDX_W-1:0]     rd_idx, rs1_idx, rs2_idx;
  logic [31:0]           sum, alu;
  logic [ADDR_WIDTH-1:0] pc_plus4, pc_plus_imm;

  function automatic logic is_legal(input logic [31:0] ir);
    logic ok;
    case (ir[6:0])
      OP_R:              ok = (ir[31:25] == 7'b0000000 && (ir[14:12] == 3'b000 ||
                               ir[14:12] == 3'b110 || ir[14:12] == 3'b111)) ||
                              (ir[31:25] == 7'b0100000 && ir[14:12] == 3'b000);
      OP_I:              ok = (ir[14:12] == 3'b000);
      OP_LOAD, OP_STORE: ok = (ir[14:12] == 3'b010);
      OP_BRANCH:         ok = (ir[14:13] == 2'b00);
      OP_JAL:            ok = 1'b1;
      default:           ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] ir);
    logic [31:0] imm;
    case (ir[6:0])
      OP_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:   imm = {{20{ir[31]}}, ir[31:20]};
    endcase
    return imm;
  endfunction

  function automatic logic [7:0] fold8(input logic [31:0] w);
    return w[7:0] | w[15:8] | w[23:16] | w[31:24];
  endfunction

  assign opcode      = ir_q[6:0];
  assign funct3      = ir_q[14:12];
  assign rd_idx      = ir_q[7 +: RIDX_W];
  assign rs1_idx     = ir_q[15 +: RIDX_W];
  assign rs2_idx     = ir_q[20 +: RIDX_W];
  assign sum         = a_q + imm_q;
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign pc_plus_imm = pc_q + imm_q[ADDR_WIDTH-1:0];

  always_comb begin
    case (funct3)
      3'b000:  alu = ir_q[30] ? (a_q - b_q) : (a_q + b_q);
      3'b111:  alu = a_q & b_q;
      3'b110:  alu = a_q | b_q;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_WIDTH'(RESET_PC);
      addr_q  <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      req_q   <= req_d;
      leds_q  <= leds_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_idx] <= res_q;
    end
  end

  // req_q is registered from the next state, so a handshake only counts once
  // the request is actually visible on the port.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    res_d   = res_q;
    leds_d  = leds_q;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (req_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs1_idx];
        b_d     = regs_q[rs2_idx];
        imm_d   = gen_imm(ir_q);
        state_d = is_legal(ir_q) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OP_R:      begin res_d = alu; state_d = S_WB; end
          OP_I:      begin res_d = sum; state_d = S_WB; end
          OP_LOAD, OP_STORE: begin
            addr_d  = {sum[ADDR_WIDTH-1:2], 2'b00};
            state_d = S_MEM;
          end
          OP_BRANCH: begin
            pc_d    = ((a_q == b_q) != funct3[0]) ? pc_plus_imm : pc_plus4;
            state_d = S_FETCH;
          end
          OP_JAL:    begin res_d = 32'(pc_plus4); pc_d = pc_plus_imm; state_d = S_WB; end
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (req_q && mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            res_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = (rd_idx != '0);
        leds_d  = fold8(res_q);
        if (opcode != OP_JAL) pc_d = pc_plus4;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    req_d = (state_d == S_FETCH) || (state_d == S_MEM);
  end

  always_comb begin
    mem_we    = req_q && (state_q == S_MEM) && (opcode == OP_STORE);
    mem_addr  = '0;
    if (req_q) mem_addr = (state_q == S_FETCH) ? pc_q : addr_q;
    mem_wdata = mem_we ? b_q : '0;
    retire    = ((state_q == S_EXEC) && (opcode == OP_BRANCH)) ||
                ((state_q == S_MEM) && req_q && mem_ready && (opcode == OP_STORE)) ||
                (state_q == S_WB);
    halt      = (state_q == S_TRAP);
  end

  assign mem_req = req_q;
  assign pc      = pc_q;
  assign leds    = leds_q;
endmodule

// File: tb/tb_multi_cycle_core.sv
// Directed bench for multi_cycle_core: a 1 KB unified memory with a programmable
// wait count, plus a second 6-bit-address instance for PC wrap-around.
module tb_multi_cycle_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [9:0]  mem_addr, pc;
  logic [31:0] mem_wdata, mem_rdata;
  logic [7:0]  leds;

  logic        rst2 = 1'b1;
  logic        mem_req2, mem_we2, retire2, halt2;
  logic        mem_ready2 = 1'b1;
  logic [5:0]  mem_addr2, pc2;
  logic [31:0] mem_wdata2;
  logic [31:0] mem_rdata2 = 32'h0010_0093;
  logic [7:0]  leds2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [256];
  logic        ld_en = 1'b0, ld_clr = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  int          wait_n = 0;
  int          wcnt = 0;

  assign mem_ready = mem_req && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  multi_cycle_core dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retire(retire), .halt(halt), .leds(leds)
  );

  multi_cycle_core #(.ADDR_WIDTH(6), .RESET_PC(60), .NUM_REGS(32)) dut_wrap (
    .clk(clk), .rst(rst2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .pc(pc2),
    .retire(retire2), .halt(halt2), .leds(leds2)
  );

  task automatic load(input int a, input logic [31:0] d);
    ld_addr = 8'(a >> 2);
    ld_data = d;
    ld_en   = 1'b1;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic prep(input int wn);
    rst = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b1;
    @(posedge clk); #1;
    ld_clr = 1'b0;
    wait_n = wn;
  endtask

  task automatic go();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    prep(0);
    load(0, 32'h0050_0093);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, retire, halt, leds, pc} !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h ret=%b halt=%b leds=%h pc=%h, expected all 0",
                 mem_req, mem_we, mem_addr, mem_wdata, retire, halt, leds, pc);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL release_cycle_req: got %b expected 0", mem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h000 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL first_fetch: req=%b addr=%h we=%b expected req=1 addr=000 we=0", mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_alu();
    int nret;
    logic ret20;
    nret  = 0;
    ret20 = 1'b0;
    prep(0);
    load(32'h00, 32'h0050_0093);
    load(32'h04, 32'h0030_0113);
    load(32'h08, 32'h4020_81B3);
    load(32'h0C, 32'h0020_F233);
    load(32'h10, 32'h0020_E2B3);
    go();
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (retire) nret++;
      if (c == 20) ret20 = retire;
    end
    n_cmp++;
    if (nret !== 5) begin n_bad++; $display("FAIL alu_retire_count: got %0d expected 5", nret); end
    n_cmp++;
    if (ret20 !== 1'b1) begin n_bad++; $display("FAIL alu_retire_cycle20: got %b expected 1", ret20); end
    @(posedge clk); #1;
    n_cmp++;
    if (dut.regs_q[3] !== 32'd2) begin n_bad++; $display("FAIL alu_sub_x3: got %h expected 2", dut.regs_q[3]); end
    n_cmp++;
    if (dut.regs_q[4] !== 32'd1) begin n_bad++; $display("FAIL alu_and_x4: got %h expected 1", dut.regs_q[4]); end
    n_cmp++;
    if (dut.regs_q[5] !== 32'd7) begin n_bad++; $display("FAIL alu_or_x5: got %h expected 7", dut.regs_q[5]); end
    n_cmp++;
    if (leds !== 8'h07) begin n_bad++; $display("FAIL alu_leds: got %h expected 07", leds); end
  endtask

  task automatic test_mem_wait();
    int start, lw_cyc, nwait;
    start  = -1;
    lw_cyc = -1;
    nwait  = 0;
    prep(2);
    load(32'h00, 32'h0050_0093);
    load(32'h04, 32'h00C0_006F);
    load(32'h10, 32'h0010_2423);
    load(32'h14, 32'h0080_2303);
    go();
    for (int c = 0; c < 300 && lw_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_req && mem_we && !mem_ready) begin
        nwait++;
        n_cmp++;
        if (mem_addr !== 10'h008 || mem_wdata !== 32'd5) begin
          n_bad++;
          $display("FAIL sw_wait_hold: addr=%h wdata=%h expected addr=008 wdata=5", mem_addr, mem_wdata);
        end
      end
      if (retire && mem_we && pc == 10'h010) start = c;
      if (retire && pc == 10'h014 && start >= 0) lw_cyc = c - start;
    end
    n_cmp++;
    if (nwait !== 2) begin n_bad++; $display("FAIL sw_wait_cycles: got %0d expected 2", nwait); end
    n_cmp++;
    if (lw_cyc !== 9) begin n_bad++; $display("FAIL lw_cycles: got %0d expected 9", lw_cyc); end
    @(posedge clk); #1;
    n_cmp++;
    if (dut.regs_q[6] !== 32'd5) begin n_bad++; $display("FAIL lw_x6: got %h expected 5", dut.regs_q[6]); end
    n_cmp++;
    if (mem[2] !== 32'd5) begin n_bad++; $display("FAIL sw_mem: got %h expected 5", mem[2]); end
    n_cmp++;
    if (leds !== 8'h05) begin n_bad++; $display("FAIL lw_leds: got %h expected 05", leds); end
  endtask

  task automatic test_branch();
    logic [9:0] exp_fa [7];
    logic [9:0] fa [7];
    int         fc [7];
    int         nf;
    exp_fa = '{10'h000, 10'h004, 10'h010, 10'h018, 10'h01C, 10'h020, 10'h018};
    for (int i = 0; i < 7; i++) begin fa[i] = 10'h3FF; fc[i] = 0; end
    nf = 0;
    prep(0);
    load(32'h00, 32'h0050_0093);
    load(32'h04, 32'h00C0_006F);
    load(32'h10, 32'h0010_8463);
    load(32'h18, 32'h0010_9463);
    load(32'h1C, 32'h0010_0413);
    load(32'h20, 32'hFF9F_F3EF);
    go();
    for (int c = 0; c < 200 && nf < 7; c++) begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        fa[nf] = mem_addr;
        fc[nf] = c;
        nf++;
      end
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (fa[i] !== exp_fa[i]) begin
        n_bad++;
        $display("FAIL fetch_order[%0d]: got %h expected %h", i, fa[i], exp_fa[i]);
      end
    end
    n_cmp++;
    if (fc[3] - fc[2] !== 3) begin n_bad++; $display("FAIL beq_taken_cycles: got %0d expected 3", fc[3] - fc[2]); end
    n_cmp++;
    if (fc[4] - fc[3] !== 3) begin n_bad++; $display("FAIL bne_not_taken_cycles: got %0d expected 3", fc[4] - fc[3]); end
    n_cmp++;
    if (fc[6] - fc[5] !== 4) begin n_bad++; $display("FAIL jal_cycles: got %0d expected 4", fc[6] - fc[5]); end
    n_cmp++;
    if (pc !== 10'h018) begin n_bad++; $display("FAIL jal_pc: got %h expected 018", pc); end
    n_cmp++;
    if (dut.regs_q[7] !== 32'h24) begin n_bad++; $display("FAIL jal_link_x7: got %h expected 24", dut.regs_q[7]); end
    n_cmp++;
    if (dut.regs_q[8] !== 32'h1) begin n_bad++; $display("FAIL addi_x8: got %h expected 1", dut.regs_q[8]); end
    n_cmp++;
    if (leds !== 8'h24) begin n_bad++; $display("FAIL jal_leds: got %h expected 24", leds); end
  endtask

  task automatic test_trap();
    logic got;
    got = 1'b0;
    prep(0);
    load(32'h00, 32'h0050_0093);
    load(32'h04, 32'h0000_007F);
    go();
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (halt) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL trap_reached: got %b expected 1", got); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (halt !== 1'b1 || mem_req !== 1'b0 || pc !== 10'h004) begin
        n_bad++;
        $display("FAIL trap_hold: halt=%b req=%b pc=%h expected halt=1 req=0 pc=004", halt, mem_req, pc);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (halt !== 1'b0 || pc !== 10'h000) begin
      n_bad++;
      $display("FAIL trap_cleared: halt=%b pc=%h expected halt=0 pc=000", halt, pc);
    end
  endtask

  task automatic test_x0();
    logic got;
    prep(0);
    load(32'h00, 32'h0090_0013);
    load(32'h04, 32'h0000_64B3);
    go();
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (retire) got = 1'b1;
    end
    n_cmp++;
    if (got !== 1'b1) begin n_bad++; $display("FAIL x0_retire: got %b expected 1", got); end
    @(posedge clk); #1;
    n_cmp++;
    if (leds !== 8'h09) begin n_bad++; $display("FAIL x0_leds: got %h expected 09", leds); end
    n_cmp++;
    if (dut.regs_q[0] !== 32'd0) begin n_bad++; $display("FAIL x0_reg: got %h expected 0", dut.regs_q[0]); end
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (retire) got = 1'b1;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dut.regs_q[9] !== 32'd0 || leds !== 8'h00 || got !== 1'b1) begin
      n_bad++;
      $display("FAIL x0_reads_zero: x9=%h leds=%h retired=%b expected x9=0 leds=00 retired=1",
               dut.regs_q[9], leds, got);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] fa [2];
    int         nf, nret;
    fa[0] = 6'h3F;
    fa[1] = 6'h3F;
    nf    = 0;
    nret  = 0;
    rst2  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst2 = 1'b0;
    for (int c = 0; c < 50 && nf < 2; c++) begin
      @(negedge clk);
      if (retire2) nret++;
      if (mem_req2 && mem_ready2) begin
        fa[nf] = mem_addr2;
        nf++;
      end
    end
    n_cmp++;
    if (fa[0] !== 6'h3C) begin n_bad++; $display("FAIL wrap_first_fetch: got %h expected 3c", fa[0]); end
    n_cmp++;
    if (fa[1] !== 6'h00) begin n_bad++; $display("FAIL wrap_second_fetch: got %h expected 00", fa[1]); end
    n_cmp++;
    if (pc2 !== 6'h00 || leds2 !== 8'h01 || nret !== 1 || halt2 !== 1'b0 ||
        mem_we2 !== 1'b0 || mem_wdata2 !== 32'd0) begin
      n_bad++;
      $display("FAIL wrap_state: pc=%h leds=%h retires=%0d halt=%b we=%b wdata=%h expected pc=00 leds=01 retires=1 halt=0 we=0 wdata=0",
               pc2, leds2, nret, halt2, mem_we2, mem_wdata2);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_trap();
    test_x0();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
